axis_rx_fifo: RTL
=================

Name: axis_rx_fifo

Overview:
- AXI-Stream slave-side receiver. Terminates a stream from an axis_m-style transmitter and buffers beats in a small FIFO.
- Enforces a maximum packet length: oversize packets are truncated and their tail is discarded.
- Presents beats to a local consumer through a first-word-fall-through valid/ready port.
- Sits at the receive end of the stream link, in place of or behind axis_s.

Parameters:
- DATA_W, 32, width of tdata and data.
- DEPTH, 8, number of FIFO entries; power of 2, minimum 2.
- MAX_PKT, 40, maximum beats per packet, including the beat carrying tlast.

Ports:
- aclk  in  1  clock; all logic on posedge.
- areset  in  1  synchronous, active-high reset.
- tvalid  in  1  stream beat valid.
- tready  out  1  stream beat accepted when tvalid and tready are both high.
- tdata  in  DATA_W  stream data.
- tlast  in  1  last beat of packet.
- data  out  DATA_W  FIFO head data.
- valid  out  1  FIFO head valid (FIFO not empty).
- last  out  1  FIFO head is a packet end.
- ready  in  1  consumer pops the head when valid and ready are both high.
- finish  out  1  one-cycle pulse, the cycle after a beat with last=1 is popped.

Behaviour:
- Clock and reset (already decided): one clock, aclk; reset areset is synchronous and active-high.
- Reset values:
  - tready=0, valid=0, last=0, finish=0, data=0.
  - FIFO empty, FSM in IDLE, beat counter=0, statistics cleared.
- Reset mid-packet: FIFO contents are discarded and the FSM returns to IDLE. The first beat after reset is treated as the start of a new packet.
- Stream acceptance:
  - tready=1 when state is DROP, or when the FIFO is not full. tready=0 while areset is high.
  - tready is combinational from registered state only, never from tvalid.
  - An accepted beat in IDLE or IN_PKT writes {last_flag, tdata} to the FIFO.
  - Full FIFO: tready=0. There is no same-cycle bypass; a pop in that cycle frees space for the next cycle.
- FSM, per accepted beat, with beat counter cnt:
  - IDLE: cnt := 1. If tlast, store the beat with last=1 and stay in IDLE. Otherwise go to IN_PKT.
  - IN_PKT, case tlast: store with last=1, cnt := 0, go to IDLE.
  - IN_PKT, case cnt+1 == MAX_PKT and tlast=0: store with last forced to 1, pulse len_err, go to DROP.
  - IN_PKT, otherwise: cnt++.
  - DROP: accept and discard beats, nothing is written. A beat with tlast returns the FSM to IDLE.
  - MAX_PKT=1: every beat is stored with last=1. A non-tlast beat enters DROP.
- Consumer port:
  - FWFT: valid = FIFO not empty; data and last are the head entry.
  - Latency: a beat accepted at edge N is visible at the head after edge N, i.e. valid in cycle N+1 when the FIFO was empty.
  - A simultaneous push and pop is legal at any occupancy below full, and occupancy is unchanged.
  - Pointers are log2(DEPTH) bits plus a wrap bit. Full is detected when the addresses are equal and the wrap bits differ.
- finish is registered: high for exactly one cycle after the edge that pops a last=1 entry.

Optional Feature:
- Macro: AXIS_RX_STATS_EN.
- When defined, two extra outputs are added:
  - pkt_cnt, 16 bits: increments on each packet end written to the FIFO (tlast or forced last); wraps 0xFFFF to 0.
  - len_err, 1 bit: one-cycle pulse on truncation; no separate pulse when the DROP tail later ends.
  - Both reset to 0.
- When not defined, these ports and their counters are absent. Stream and consumer behaviour is identical.

Test Plan:
- Reset, then 3 beats 0xAAAABBBB x2 and 0xCCCCDDDD with tlast on beat 3, ready=1:
  - Consumer sees the same 3 words in order, with last only on the third.
  - finish pulses once.
  - pkt_cnt=1.
- ready=0 while sending 10 beats, DEPTH=8:
  - tready drops after the 8th acceptance; beats 9 and 10 are held by the source.
  - Raising ready drains all 10 words in order with no loss or duplication.
- 45-beat packet, MAX_PKT=40, tlast on beat 45:
  - 40 words are stored, the 40th with last=1.
  - len_err pulses once at beat 40.
  - Beats 41–45 are accepted with tready=1 and never appear at the consumer.
  - pkt_cnt=1.
- Continuous stream with ready=1, FIFO neither empty nor full:
  - Simultaneous push and pop every cycle; occupancy stays constant.
  - Throughput of 1 beat/cycle.
- areset asserted mid-packet after 5 beats:
  - Next cycle: valid=0, tready=0 while reset is held.
  - After release, a new 2-beat packet is delivered alone with correct last.
- Back-to-back single-beat packets (tvalid=tlast=1 for 4 cycles):
  - 4 entries, each with last=1.
  - finish pulses 4 times.
  - pkt_cnt=4.

Source files
------------

// File: rtl/axis_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_rx_fifo
// Brief    : AXI-Stream receiver with a FWFT buffer and max-length truncation.
//            Optional statistics outputs: define AXIS_RX_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axis_rx_fifo #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int MAX_PKT = 40
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              tvalid,
  output logic              tready,
  input  logic [DATA_W-1:0] tdata,
  input  logic              tlast,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              last,
  input  logic              ready,
  output logic              finish
`ifdef AXIS_RX_STATS_EN
  ,
  output logic [15:0]       pkt_cnt,
  output logic              len_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_PKT + 1);
  localparam logic [CW-1:0] C_MAX = CW'(MAX_PKT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    DROP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            finish_q, finish_d;
  logic [DATA_W:0] mem_q [DEPTH];

  logic full, empty, accept, push, push_last, pop, trunc;

  // Extra pointer bit distinguishes full from empty when addresses match.
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign tready = !areset && ((state_q == DROP) || !full);
  assign accept = tvalid && tready;
  assign valid  = !empty;
  assign data   = valid ? mem_q[rd_ptr_q[AW-1:0]][DATA_W-1:0] : '0;
  assign last   = valid && mem_q[rd_ptr_q[AW-1:0]][DATA_W];
  assign pop    = valid && ready;
  assign finish = finish_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_last = 1'b0;
    trunc     = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          push  = 1'b1;
          cnt_d = CW'(1);
          if (tlast) begin
            push_last = 1'b1;
          end else if (MAX_PKT == 1) begin
            push_last = 1'b1;
            trunc     = 1'b1;
            state_d   = DROP;
          end else begin
            state_d = IN_PKT;
          end
        end
        IN_PKT: begin
          push = 1'b1;
          if (tlast) begin
            push_last = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else if (cnt_q + 1'b1 == C_MAX) begin
            // Force a packet end on the final allowed beat; the tail is dropped.
            push_last = 1'b1;
            trunc     = 1'b1;
            cnt_d     = '0;
            state_d   = DROP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DROP: begin
          if (tlast) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    finish_d = pop && last;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      finish_q <= finish_d;
    end
  end

  // Storage needs no reset: outputs are gated by the empty flag.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {push_last, tdata};
  end

`ifdef AXIS_RX_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic        len_err_q, len_err_d;

  always_comb begin
    pkt_cnt_d = (push && push_last) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
    len_err_d = trunc;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_cnt_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign len_err = len_err_q;
`else
  logic unused_stats;
  assign unused_stats = trunc;
`endif

endmodule
`default_nettype wire
